// File: rtl/ez8_pkg.sv
// rtl/ez8_pkg.sv - shared ez8 definitions: program loader state enum and default frame header
package ez8_pkg;

  localparam logic [7:0] EZ8_HEADER = 8'hA5;

  typedef enum logic [3:0] {
    LDR_IDLE    = 4'd0,
    LDR_ADDR_HI = 4'd1,
    LDR_ADDR_LO = 4'd2,
    LDR_CNT_HI  = 4'd3,
    LDR_CNT_LO  = 4'd4,
    LDR_DATA_HI = 4'd5,
    LDR_DATA_LO = 4'd6,
    LDR_CSUM    = 4'd7,
    LDR_START   = 4'd8,
    LDR_RUN     = 4'd9
  } ldr_state_e;

endpackage

// File: rtl/ez8_prog_loader.sv
// rtl/ez8_prog_loader.sv - framed byte stream to ez8_cpu instruction-write port loader
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_data/in_valid/in_ready    byte stream in (accepted when in_valid && in_ready)
//   instr_writeaddr/_writedata   instruction write address / 16-bit word
//   instr_write_en               one-cycle write strobe
//   cpu_pause, cpu_reset         CPU freeze level and active-high reset pulse
//   done, err                    last frame started the CPU / last frame failed checksum
module ez8_prog_loader
  import ez8_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 12,   // must be <= 16
  parameter logic [7:0]  HEADER       = EZ8_HEADER,
  parameter int          RESET_CYCLES = 2     // must be >= 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] instr_writeaddr,
  output logic [15:0]           instr_writedata,
  output logic                  instr_write_en,
  output logic                  cpu_pause,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  err
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES - 1);

  ldr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           data_q;
  logic                  we_q;
  logic                  pause_q;
  logic                  cpu_rst_q;
  logic                  done_q;
  logic                  err_q;
  logic                  ready_q;
  logic [7:0]            hi_q;     // holds the high byte of the current 16-bit field
  logic [15:0]           cnt_q;    // words still to be received
  logic [7:0]            csum_q;   // running XOR of bytes after HEADER
  logic [RCW-1:0]        rcnt_q;   // remaining cpu_reset cycles minus one

  logic        accept;
  logic [15:0] word;

  assign accept = in_valid && ready_q;
  assign word   = {hi_q, in_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LDR_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      pause_q   <= 1'b1;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      hi_q      <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      we_q <= 1'b0;
      // Advance the address once the strobe cycle has presented it; wraps naturally.
      if (we_q) addr_q <= addr_q + 1'b1;

      case (state_q)
        LDR_IDLE, LDR_RUN: begin
          if (accept && in_data == HEADER) begin
            state_q <= LDR_ADDR_HI;
            pause_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            csum_q  <= '0;
          end
        end
        LDR_ADDR_HI: if (accept) begin
          hi_q    <= in_data;
          csum_q  <= csum_q ^ in_data;
          state_q <= LDR_ADDR_LO;
        end
        LDR_ADDR_LO: if (accept) begin
          addr_q  <= word[ADDR_WIDTH-1:0];
          csum_q  <= csum_q ^ in_data;
          state_q <= LDR_CNT_HI;
        end
        LDR_CNT_HI: if (accept) begin
          hi_q    <= in_data;
          csum_q  <= csum_q ^ in_data;
          state_q <= LDR_CNT_LO;
        end
        LDR_CNT_LO: if (accept) begin
          cnt_q   <= word;
          csum_q  <= csum_q ^ in_data;
          state_q <= (word == 16'd0) ? LDR_CSUM : LDR_DATA_HI;
        end
        LDR_DATA_HI: if (accept) begin
          hi_q    <= in_data;
          csum_q  <= csum_q ^ in_data;
          state_q <= LDR_DATA_LO;
        end
        LDR_DATA_LO: if (accept) begin
          data_q  <= word;
          we_q    <= 1'b1;
          cnt_q   <= cnt_q - 16'd1;
          csum_q  <= csum_q ^ in_data;
          state_q <= (cnt_q == 16'd1) ? LDR_CSUM : LDR_DATA_HI;
        end
        LDR_CSUM: if (accept) begin
          if (in_data == csum_q) begin
            state_q   <= LDR_START;
            pause_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            rcnt_q    <= RST_LOAD;
          end else begin
            // Words already written stay written; CPU remains frozen.
            err_q   <= 1'b1;
            state_q <= LDR_IDLE;
          end
        end
        LDR_START: begin
          if (rcnt_q == '0) begin
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= LDR_RUN;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        default: state_q <= LDR_IDLE;
      endcase
    end
  end

  assign in_ready        = ready_q;
  assign instr_writeaddr = addr_q;
  assign instr_writedata = data_q;
  assign instr_write_en  = we_q;
  assign cpu_pause       = pause_q;
  assign cpu_reset       = cpu_rst_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule
